// File: rtl/trap_causes.sv
// Shared trap encodings: exception and interrupt codes, pending-bit mask,
// CSR write selects and trap-controller FSM states.
package trap_causes;

  localparam int unsigned CAUSE_W = 4;

  typedef enum logic [CAUSE_W-1:0] {
    EXC_INSTR_MISALIGNED = 4'd0,
    EXC_INSTR_ACCESS     = 4'd1,
    EXC_ILLEGAL_INSTR    = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_LOAD_ACCESS      = 4'd5,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_STORE_ACCESS     = 4'd7,
    EXC_ECALL_U          = 4'd8,
    EXC_ECALL_S          = 4'd9,
    EXC_ECALL_M          = 4'd11,
    EXC_INSTR_PAGE       = 4'd12,
    EXC_LOAD_PAGE        = 4'd13,
    EXC_STORE_PAGE       = 4'd15
  } exceptions;

  localparam logic [CAUSE_W-1:0] IRQ_CODE_MSI = 4'd3;
  localparam logic [CAUSE_W-1:0] IRQ_CODE_MTI = 4'd7;
  localparam logic [CAUSE_W-1:0] IRQ_CODE_MEI = 4'd11;

  localparam int unsigned MIP_MSIP = 3;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;
  localparam logic [11:0] MIP_MASK = 12'h888;

  typedef enum logic [1:0] {
    CSR_MSTATUS = 2'd0,
    CSR_MEPC    = 2'd1,
    CSR_MCAUSE  = 2'd2,
    CSR_MTVAL   = 2'd3
  } csr_sel_e;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } trap_state_e;

  // Fixed interrupt priority MEI > MSI > MTI; caller guarantees one is pending.
  function automatic logic [CAUSE_W-1:0] irq_select(input logic mei, input logic msi);
    if (mei) begin
      return IRQ_CODE_MEI;
    end else if (msi) begin
      return IRQ_CODE_MSI;
    end
    return IRQ_CODE_MTI;
  endfunction

endpackage

// File: rtl/trap_irq_sync.sv
// Multi-flop synchroniser chain for a bundle of asynchronous interrupt lines.
module trap_irq_sync #(
  parameter int unsigned IRQ_SYNC_STAGES = 2,
  parameter int unsigned WIDTH           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] irq_async,
  output logic [WIDTH-1:0] irq_sync
);

  logic [WIDTH-1:0] stage_q [IRQ_SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < IRQ_SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= irq_async;
      for (int unsigned i = 1; i < IRQ_SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign irq_sync = stage_q[IRQ_SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// M-mode trap controller: exceptions, interrupts, mret and CSR writes feed a
// registered fetch redirect. Define TRAP_VECTORED_EN for vectored interrupt entry.
module trap_ctrl
  import trap_causes::*;
#(
  parameter int unsigned XLEN            = 64,
  parameter int unsigned ALEN            = 64,
  parameter int unsigned ILEN            = 32,
  parameter int unsigned IRQ_SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exec_trap_valid,
  input  logic [3:0]      exec_trap_cause,
  input  logic [ALEN-1:0] exec_trap_instr_addr,
  input  logic [ALEN-1:0] exec_branch_target,
  input  logic [ALEN-1:0] exec_mem_fault_addr,
  input  logic [ILEN-1:0] exec_trap_instr,
  input  logic            exec_instr_valid,
  input  logic [ALEN-1:0] exec_next_pc,
  input  logic            exec_mret,
  input  logic            irq_m_ext,
  input  logic            irq_m_timer,
  input  logic            irq_m_soft,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mie,
  input  logic            csr_wr_en,
  input  logic [1:0]      csr_wr_sel,
  input  logic [XLEN-1:0] csr_wr_data,
  output logic            redirect_valid,
  output logic [ALEN-1:0] redirect_target,
  input  logic            redirect_ready,
  output logic            trap_busy,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            mstatus_mie,
  output logic            mstatus_mpie,
  output logic [XLEN-1:0] mip
);

  trap_state_e     state_q, state_d;
  logic            valid_d;
  logic [ALEN-1:0] target_d;
  logic [XLEN-1:0] mepc_d, mcause_d, mtval_d;
  logic            mie_d, mpie_d;

  logic [2:0]      irq_sync;
  logic [XLEN-1:0] irq_pend;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic [ALEN-1:0] trap_base;
  logic [ALEN-1:0] irq_target;
  logic [XLEN-1:0] exc_mtval;

  trap_irq_sync #(
    .IRQ_SYNC_STAGES(IRQ_SYNC_STAGES),
    .WIDTH          (3)
  ) u_irq_sync (
    .clk      (clk),
    .rst      (rst),
    .irq_async({irq_m_ext, irq_m_timer, irq_m_soft}),
    .irq_sync (irq_sync)
  );

  // mip comes straight from the last synchroniser stage.
  always_comb begin
    mip           = '0;
    mip[MIP_MEIP] = irq_sync[2];
    mip[MIP_MTIP] = irq_sync[1];
    mip[MIP_MSIP] = irq_sync[0];
  end

  assign irq_pend  = mip & mie & XLEN'(MIP_MASK);
  assign irq_take  = mstatus_mie && exec_instr_valid && (|irq_pend);
  assign irq_code  = irq_select(irq_pend[MIP_MEIP], irq_pend[MIP_MSIP]);
  assign trap_base = ALEN'({mtvec[XLEN-1:2], 2'b00});

`ifdef TRAP_VECTORED_EN
  assign irq_target = (mtvec[1:0] == 2'b01) ? trap_base + ALEN'({irq_code, 2'b00}) : trap_base;
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec[1:0];
  assign irq_target        = trap_base;
`endif

  always_comb begin
    exc_mtval = '0;
    case (exec_trap_cause)
      EXC_INSTR_MISALIGNED:              exc_mtval = XLEN'(exec_branch_target);
      EXC_INSTR_ACCESS, EXC_INSTR_PAGE:  exc_mtval = XLEN'(exec_trap_instr_addr);
      EXC_ILLEGAL_INSTR:                 exc_mtval = XLEN'(exec_trap_instr);
      EXC_LOAD_MISALIGNED, EXC_LOAD_ACCESS, EXC_STORE_MISALIGNED,
      EXC_STORE_ACCESS, EXC_LOAD_PAGE, EXC_STORE_PAGE:
                                         exc_mtval = XLEN'(exec_mem_fault_addr);
      default:                           exc_mtval = '0;
    endcase
  end

  // Next-state: events only arbitrated in IDLE; REDIRECT waits for the handshake.
  always_comb begin
    state_d  = state_q;
    valid_d  = redirect_valid;
    target_d = redirect_target;
    mepc_d   = mepc;
    mcause_d = mcause;
    mtval_d  = mtval;
    mie_d    = mstatus_mie;
    mpie_d   = mstatus_mpie;
    case (state_q)
      IDLE: begin
        if (exec_trap_valid) begin
          state_d  = REDIRECT;
          valid_d  = 1'b1;
          target_d = trap_base;
          mepc_d   = XLEN'(exec_trap_instr_addr);
          mcause_d = {1'b0, (XLEN-1)'(exec_trap_cause)};
          mtval_d  = exc_mtval;
          mpie_d   = mstatus_mie;
          mie_d    = 1'b0;
        end else if (exec_mret) begin
          state_d  = REDIRECT;
          valid_d  = 1'b1;
          target_d = ALEN'(mepc);
          mie_d    = mstatus_mpie;
          mpie_d   = 1'b1;
        end else if (irq_take) begin
          state_d  = REDIRECT;
          valid_d  = 1'b1;
          target_d = irq_target;
          mepc_d   = XLEN'(exec_next_pc);
          mcause_d = {1'b1, (XLEN-1)'(irq_code)};
          mtval_d  = '0;
          mpie_d   = mstatus_mie;
          mie_d    = 1'b0;
        end else if (csr_wr_en) begin
          case (csr_sel_e'(csr_wr_sel))
            CSR_MSTATUS: begin
              mie_d  = csr_wr_data[3];
              mpie_d = csr_wr_data[7];
            end
            CSR_MEPC:    mepc_d   = {csr_wr_data[XLEN-1:2], 2'b00};
            CSR_MCAUSE:  mcause_d = csr_wr_data;
            CSR_MTVAL:   mtval_d  = csr_wr_data;
            default:     mtval_d  = mtval;
          endcase
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
      mepc            <= '0;
      mcause          <= '0;
      mtval           <= '0;
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
    end else begin
      state_q         <= state_d;
      redirect_valid  <= valid_d;
      redirect_target <= target_d;
      mepc            <= mepc_d;
      mcause          <= mcause_d;
      mtval           <= mtval_d;
      mstatus_mie     <= mie_d;
      mstatus_mpie    <= mpie_d;
    end
  end

  assign trap_busy = (state_q == REDIRECT);

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl: vector table plus multi-cycle sequences.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ALEN = 64;
  localparam int unsigned ILEN = 32;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            exec_trap_valid;
  logic [3:0]      exec_trap_cause;
  logic [ALEN-1:0] exec_trap_instr_addr;
  logic [ALEN-1:0] exec_branch_target;
  logic [ALEN-1:0] exec_mem_fault_addr;
  logic [ILEN-1:0] exec_trap_instr;
  logic            exec_instr_valid;
  logic [ALEN-1:0] exec_next_pc;
  logic            exec_mret;
  logic            irq_m_ext, irq_m_timer, irq_m_soft;
  logic [XLEN-1:0] mtvec, mie;
  logic            csr_wr_en;
  logic [1:0]      csr_wr_sel;
  logic [XLEN-1:0] csr_wr_data;
  logic            redirect_valid;
  logic [ALEN-1:0] redirect_target;
  logic            redirect_ready;
  logic            trap_busy;
  logic [XLEN-1:0] mepc, mcause, mtval, mip;
  logic            mstatus_mie, mstatus_mpie;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN), .ALEN(ALEN), .ILEN(ILEN), .IRQ_SYNC_STAGES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .exec_trap_valid     (exec_trap_valid),
    .exec_trap_cause     (exec_trap_cause),
    .exec_trap_instr_addr(exec_trap_instr_addr),
    .exec_branch_target  (exec_branch_target),
    .exec_mem_fault_addr (exec_mem_fault_addr),
    .exec_trap_instr     (exec_trap_instr),
    .exec_instr_valid    (exec_instr_valid),
    .exec_next_pc        (exec_next_pc),
    .exec_mret           (exec_mret),
    .irq_m_ext           (irq_m_ext),
    .irq_m_timer         (irq_m_timer),
    .irq_m_soft          (irq_m_soft),
    .mtvec               (mtvec),
    .mie                 (mie),
    .csr_wr_en           (csr_wr_en),
    .csr_wr_sel          (csr_wr_sel),
    .csr_wr_data         (csr_wr_data),
    .redirect_valid      (redirect_valid),
    .redirect_target     (redirect_target),
    .redirect_ready      (redirect_ready),
    .trap_busy           (trap_busy),
    .mepc                (mepc),
    .mcause              (mcause),
    .mtval               (mtval),
    .mstatus_mie         (mstatus_mie),
    .mstatus_mpie        (mstatus_mpie),
    .mip                 (mip)
  );

  typedef struct {
    logic        tv;
    logic [3:0]  cause;
    logic [63:0] pc;
    logic [63:0] br;
    logic [63:0] mem;
    logic [31:0] instr;
    logic        mret;
    logic        csr_en;
    logic [1:0]  sel;
    logic [63:0] data;
    logic        e_valid;
    logic [63:0] e_target;
    logic [63:0] e_mepc;
    logic [63:0] e_mcause;
    logic [63:0] e_mtval;
    logic        e_mie;
    logic        e_mpie;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    exec_trap_valid      = 1'b0;
    exec_trap_cause      = 4'd0;
    exec_trap_instr_addr = '0;
    exec_branch_target   = '0;
    exec_mem_fault_addr  = '0;
    exec_trap_instr      = '0;
    exec_instr_valid     = 1'b0;
    exec_next_pc         = '0;
    exec_mret            = 1'b0;
    csr_wr_en            = 1'b0;
    csr_wr_sel           = 2'd0;
    csr_wr_data          = '0;
  endtask

  task automatic apply(input vec_t v);
    exec_trap_valid      = v.tv;
    exec_trap_cause      = v.cause;
    exec_trap_instr_addr = v.pc;
    exec_branch_target   = v.br;
    exec_mem_fault_addr  = v.mem;
    exec_trap_instr      = v.instr;
    exec_mret            = v.mret;
    csr_wr_en            = v.csr_en;
    csr_wr_sel           = v.sel;
    csr_wr_data          = v.data;
  endtask

  task automatic release_redirect(input string name);
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    chk1({name, " released valid"}, redirect_valid, 1'b0);
    chk1({name, " released busy"}, trap_busy, 1'b0);
  endtask

  task automatic csr_write(input logic [1:0] sel, input logic [63:0] data);
    csr_wr_en   = 1'b1;
    csr_wr_sel  = sel;
    csr_wr_data = data;
    step();
    clear_events();
  endtask

  task automatic chk_state(input string name, input logic [63:0] t, input logic [63:0] pc,
                           input logic [63:0] c, input logic [63:0] tv,
                           input logic e_mie, input logic e_mpie);
    chk1({name, " valid"}, redirect_valid, 1'b1);
    chk1({name, " busy"}, trap_busy, 1'b1);
    chk({name, " target"}, redirect_target, t);
    chk({name, " mepc"}, mepc, pc);
    chk({name, " mcause"}, mcause, c);
    chk({name, " mtval"}, mtval, tv);
    chk1({name, " mie"}, mstatus_mie, e_mie);
    chk1({name, " mpie"}, mstatus_mpie, e_mpie);
  endtask

  initial begin
    logic [63:0] held_target;
    logic [63:0] vec_tgt;

    vecs[0]  = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b1, 2'd0, 64'h8,
                 1'b0, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'd2,  64'h8000_0100, 64'h0, 64'h0, 32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'h8000_0100, 64'h2, 64'hFFFF_FFFF, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b0, 2'd0, 64'h0,
                 1'b1, 64'h8000_0100, 64'h8000_0100, 64'h2, 64'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 4'd0,  64'h200, 64'h302, 64'h999, 32'h1234, 1'b0, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'h200, 64'h0, 64'h302, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b1, 2'd1, 64'h1237,
                 1'b0, 64'h0, 64'h1234, 64'h0, 64'h302, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b1, 2'd2, 64'hDEAD,
                 1'b0, 64'h0, 64'h1234, 64'hDEAD, 64'h302, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b1, 2'd3, 64'hBEEF,
                 1'b0, 64'h0, 64'h1234, 64'hDEAD, 64'hBEEF, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 4'd5,  64'h400, 64'h11, 64'h1003, 32'h0, 1'b0, 1'b1, 2'd1, 64'h5555,
                 1'b1, BASE, 64'h400, 64'h5, 64'h1003, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'd12, 64'h600, 64'h11, 64'h22, 32'h0, 1'b0, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'h600, 64'hC, 64'h600, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'd11, 64'h700, 64'h1, 64'h2, 32'h33, 1'b0, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'h700, 64'hB, 64'h0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'd15, 64'h800, 64'h5, 64'hABC0, 32'h0, 1'b0, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'h800, 64'hF, 64'hABC0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b0, 1'b1, 2'd0, 64'h80,
                 1'b0, 64'h0, 64'h800, 64'hF, 64'hABC0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b0, 2'd0, 64'h0,
                 1'b1, 64'h800, 64'h800, 64'hF, 64'hABC0, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 4'd1,  64'h900, 64'h0, 64'h0, 32'h0, 1'b1, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'h900, 64'h1, 64'h900, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 4'd0,  64'h0, 64'h0, 64'h0, 32'h0, 1'b1, 1'b1, 2'd1, 64'h7777,
                 1'b1, 64'h900, 64'h900, 64'h1, 64'h900, 1'b1, 1'b1};
    vecs[15] = '{1'b1, 4'd7,  64'hA00, 64'h0, 64'h2008, 32'h0, 1'b0, 1'b0, 2'd0, 64'h0,
                 1'b1, BASE, 64'hA00, 64'h7, 64'h2008, 1'b0, 1'b1};

    rst            = 1'b1;
    redirect_ready = 1'b0;
    irq_m_ext      = 1'b0;
    irq_m_timer    = 1'b0;
    irq_m_soft     = 1'b0;
    mtvec          = BASE;
    mie            = 64'h888;
    clear_events();
    step();
    step();
    rst = 1'b0;

    chk1("reset valid", redirect_valid, 1'b0);
    chk1("reset busy", trap_busy, 1'b0);
    chk("reset target", redirect_target, 64'h0);
    chk("reset mepc", mepc, 64'h0);
    chk("reset mcause", mcause, 64'h0);
    chk("reset mtval", mtval, 64'h0);
    chk1("reset mie", mstatus_mie, 1'b0);
    chk1("reset mpie", mstatus_mpie, 1'b0);
    chk("reset mip", mip, 64'h0);

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      step();
      clear_events();
      chk1($sformatf("v%0d valid", i), redirect_valid, vecs[i].e_valid);
      chk1($sformatf("v%0d busy", i), trap_busy, vecs[i].e_valid);
      if (vecs[i].e_valid) chk($sformatf("v%0d target", i), redirect_target, vecs[i].e_target);
      chk($sformatf("v%0d mepc", i), mepc, vecs[i].e_mepc);
      chk($sformatf("v%0d mcause", i), mcause, vecs[i].e_mcause);
      chk($sformatf("v%0d mtval", i), mtval, vecs[i].e_mtval);
      chk1($sformatf("v%0d mie", i), mstatus_mie, vecs[i].e_mie);
      chk1($sformatf("v%0d mpie", i), mstatus_mpie, vecs[i].e_mpie);
      if (vecs[i].e_valid) release_redirect($sformatf("v%0d", i));
    end

    // Illegal instruction with fetch stalling; inputs during REDIRECT are ignored.
    csr_write(2'd0, 64'h8);
    exec_trap_valid      = 1'b1;
    exec_trap_cause      = 4'd2;
    exec_trap_instr_addr = 64'h8000_0100;
    exec_trap_instr      = 32'hFFFF_FFFF;
    step();
    clear_events();
    chk_state("ill", BASE, 64'h8000_0100, 64'h2, 64'hFFFF_FFFF, 1'b0, 1'b1);
    held_target = redirect_target;
    for (int i = 0; i < 3; i++) begin
      exec_trap_valid      = 1'b1;
      exec_trap_cause      = 4'd5;
      exec_trap_instr_addr = 64'h1;
      exec_mem_fault_addr  = 64'h2;
      step();
      clear_events();
      chk1($sformatf("stall%0d busy", i), trap_busy, 1'b1);
      chk1($sformatf("stall%0d valid", i), redirect_valid, 1'b1);
      chk($sformatf("stall%0d target", i), redirect_target, held_target);
      chk($sformatf("stall%0d mepc", i), mepc, 64'h8000_0100);
    end
    release_redirect("ill");

    // Timer interrupt through the synchroniser, vectored when enabled.
    csr_write(2'd0, 64'h8);
    mtvec       = 64'h8000_0001;
    mie         = 64'h80;
    irq_m_timer = 1'b1;
    step();
    chk("mti mip edge1", mip, 64'h0);
    step();
    chk("mti mip edge2", mip, 64'h80);
    chk1("mti not yet", trap_busy, 1'b0);
    exec_instr_valid = 1'b1;
    exec_next_pc     = 64'h8000_0444;
    step();
    clear_events();
`ifdef TRAP_VECTORED_EN
    vec_tgt = 64'h8000_001C;
`else
    vec_tgt = BASE;
`endif
    chk_state("mti", vec_tgt, 64'h8000_0444, 64'h8000_0000_0000_0007, 64'h0, 1'b0, 1'b1);
    release_redirect("mti");
    irq_m_timer = 1'b0;
    step();
    step();

    // Exception wins over a pending MEI; MEI follows after mret, ahead of MSI/MTI.
    mtvec = BASE;
    mie   = 64'h888;
    csr_write(2'd0, 64'h8);
    irq_m_ext   = 1'b1;
    irq_m_soft  = 1'b1;
    irq_m_timer = 1'b1;
    step();
    step();
    chk("all mip", mip, 64'h888);
    exec_trap_valid      = 1'b1;
    exec_trap_cause      = 4'd5;
    exec_trap_instr_addr = 64'h3000;
    exec_mem_fault_addr  = 64'h1003;
    exec_instr_valid     = 1'b1;
    exec_next_pc         = 64'h3004;
    csr_wr_en            = 1'b1;
    csr_wr_sel           = 2'd3;
    csr_wr_data          = 64'h5A5A;
    step();
    clear_events();
    chk_state("ld_fault", BASE, 64'h3000, 64'h5, 64'h1003, 1'b0, 1'b1);
    release_redirect("ld_fault");
    exec_instr_valid = 1'b1;
    step();
    clear_events();
    chk1("mie0 no irq", trap_busy, 1'b0);
    exec_mret = 1'b1;
    step();
    clear_events();
    chk_state("mret", 64'h3000, 64'h3000, 64'h5, 64'h1003, 1'b1, 1'b1);
    release_redirect("mret");
    exec_instr_valid = 1'b1;
    exec_next_pc     = 64'h3004;
    step();
    clear_events();
    chk_state("mei", BASE, 64'h3004, 64'h8000_0000_0000_000B, 64'h0, 1'b0, 1'b1);
    release_redirect("mei");
    mie = 64'h88;
    csr_write(2'd0, 64'h8);
    exec_instr_valid = 1'b1;
    exec_next_pc     = 64'h3010;
    step();
    clear_events();
    chk_state("msi", BASE, 64'h3010, 64'h8000_0000_0000_0003, 64'h0, 1'b0, 1'b1);
    release_redirect("msi");
    irq_m_ext   = 1'b0;
    irq_m_soft  = 1'b0;
    irq_m_timer = 1'b0;
    step();
    step();

    // Short soft-irq pulse expires before any boundary: nothing taken.
    mie = 64'h888;
    csr_write(2'd0, 64'h8);
    irq_m_soft = 1'b1;
    step();
    irq_m_soft = 1'b0;
    step();
    step();
    step();
    exec_instr_valid = 1'b1;
    step();
    step();
    clear_events();
    chk1("pulse busy", trap_busy, 1'b0);
    chk("pulse mip", mip, 64'h0);
    chk("pulse mcause", mcause, 64'h8000_0000_0000_0003);

    // Reset while redirecting drops the request.
    exec_trap_valid      = 1'b1;
    exec_trap_cause      = 4'd2;
    exec_trap_instr_addr = 64'h100;
    exec_trap_instr      = 32'hABCD;
    step();
    clear_events();
    chk1("pre-rst valid", redirect_valid, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("rst valid", redirect_valid, 1'b0);
    chk1("rst busy", trap_busy, 1'b0);
    chk("rst mepc", mepc, 64'h0);
    chk("rst mcause", mcause, 64'h0);
    chk("rst mtval", mtval, 64'h0);
    chk1("rst mie", mstatus_mie, 1'b0);
    chk1("rst mpie", mstatus_mpie, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Sequential M-mode trap controller; next generation of the combinational exec-stage trap logic.
- Owns mepc, mcause, mtval, mstatus.MIE and mstatus.MPIE.
- Synchronises the M-mode external, timer and software interrupt lines and arbitrates them against exec-stage exceptions and mret.
- Drives a registered valid/ready redirect to fetch and stalls the pipeline (trap_busy) until fetch accepts; supports direct and vectored mtvec.

Parameters:
XLEN, 64, data/CSR width
ALEN, 64, address width
ILEN, 32, instruction width
IRQ_SYNC_STAGES, 2, synchroniser depth for irq inputs (>=2)

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
exec_trap_valid  in  1  exec reports synchronous exception
exec_trap_cause  in  4  trap_causes::exceptions code
exec_trap_instr_addr  in  ALEN  PC of faulting instr
exec_branch_target  in  ALEN  misaligned branch target
exec_mem_fault_addr  in  ALEN  faulting load/store address
exec_trap_instr  in  ILEN  instr bits (illegal instr)
exec_instr_valid  in  1  instruction completes this cycle (interrupt boundary)
exec_next_pc  in  ALEN  resume PC after completing instr
exec_mret  in  1  mret executing
irq_m_ext, irq_m_timer, irq_m_soft  in  1 each  async interrupt lines
mtvec  in  XLEN  trap vector CSR
mie  in  XLEN  interrupt-enable CSR (bits 3,7,11 used)
csr_wr_en  in  1  CSR write strobe
csr_wr_sel  in  2  0 mstatus, 1 mepc, 2 mcause, 3 mtval
csr_wr_data  in  XLEN  write data
redirect_valid  out  1  redirect request to fetch
redirect_target  out  ALEN  new PC
redirect_ready  in  1  fetch accepts
trap_busy  out  1  stall; high whenever state != IDLE
mepc, mcause, mtval  out  XLEN  CSR values
mstatus_mie, mstatus_mpie  out  1  status bits
mip  out  XLEN  pending bits 3/7/11, others 0

Behaviour:
- Reset: state IDLE; all outputs 0; synchroniser flops 0.
- FSM IDLE -> REDIRECT on an event edge; REDIRECT -> IDLE on the edge where redirect_valid && redirect_ready.
- redirect_valid/redirect_target registered and held stable while in REDIRECT.
- Events evaluated in IDLE only; inputs ignored in REDIRECT. Priority, highest first:
  - exec_trap_valid
  - exec_mret
  - interrupt
  - CSR write
- Interrupt eligible when mstatus_mie && exec_instr_valid && |(mip & mie & 0x888).
- Interrupt priority: MEI(11) > MSI(3) > MTI(7).
- Exception entry:
  - mepc <= exec_trap_instr_addr; mcause <= {0, zero-extended cause}.
  - mtval: cause 0 -> branch target; 1/12 -> instr addr; 4/5/6/7/13/15 -> mem fault addr; 2 -> zero-extended instr bits; else 0.
- Interrupt entry: mepc <= exec_next_pc; mcause <= {1, code}; mtval <= 0.
- Either entry: mpie <= mie; mie <= 0. Target = {mtvec[XLEN-1:2],2'b00}; vectored interrupt adds 4*code.
- mret: mie <= mpie; mpie <= 1; target = mepc.
- CSR write, one cycle, IDLE only, no FSM change:
  - mstatus: bit3 -> MIE, bit7 -> MPIE.
  - mepc: data with bits[1:0] forced 0.
  - mcause, mtval: full value.
  - Dropped if any higher event occurs that cycle.
- mip latency: irq line high at edge t is visible in mip after IRQ_SYNC_STAGES edges; the trap is taken at the first eligible boundary after that.
- Level-sensitive: if an irq deasserts before being taken, nothing is taken.
- rst while in REDIRECT: redirect_valid low and state IDLE on that edge; the request is lost.
- mtvec[1:0] = 2 or 3: treated as direct.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: mtvec mode 1 adds 4*code to the base for interrupts; exceptions always go to the base.
- Undefined: mode bits ignored; all traps go to the base; no vector adder synthesised.

Decomposition:
- Extend package trap_causes with:
  - interrupt code constants;
  - MIP_MASK (0x888);
  - CSR select enum (CSR_MSTATUS=0, CSR_MEPC=1, CSR_MCAUSE=2, CSR_MTVAL=3);
  - FSM state enum (IDLE, REDIRECT).
- One sub-module: trap_irq_sync (parametrised IRQ_SYNC_STAGES flop chain per line).
- mtval selection stays inline in trap_ctrl.

Test Plan:
1. Illegal instr 0xFFFFFFFF at PC 0x8000_0100, mtvec=0x8000_0000, mie=1 -> mepc=0x8000_0100, mcause=2, mtval=0xFFFFFFFF, MIE=0, MPIE=1, redirect 0x8000_0000; hold redirect_ready=0 for 3 cycles -> target stable, trap_busy=1.
2. Vectored (macro on): mtvec=0x8000_0001, mie CSR=0x80, MIE=1, irq_m_timer pulse held -> taken 2+ cycles later at boundary, mcause=0x8000...0007, target 0x8000_001C, mepc=exec_next_pc.
3. Same cycle: exec_trap_valid load fault (addr 0x1003) plus pending MEI -> exception taken, mcause=5, mtval=0x1003; MEI taken after mret restores MIE.
4. mret with mepc=0x8000_0200, MPIE=1 -> redirect 0x8000_0200, MIE=1, MPIE=1.
5. CSR write mepc=0x1237 in IDLE -> mepc reads 0x1234; same write concurrent with exception -> dropped.
6. rst asserted in REDIRECT -> next cycle redirect_valid=0, trap_busy=0, all CSRs 0.
